// File: rtl/au_pkg.sv
// Shared types and sizing for the au_div fixed-point divider.
// Optional rounding is enabled with the AU_DIV_ROUND_EN macro.
`timescale 1ns/1ps
package au_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } au_state_t;

    localparam int AU_WIDTH_1 = 4;
    localparam int AU_WIDTH_2 = 4;

`ifdef AU_DIV_ROUND_EN
    localparam int AU_ROUND_EXTRA = 1;
`else
    localparam int AU_ROUND_EXTRA = 0;
`endif

    // Restoring steps per division, guard-bit step included when rounding.
    function automatic int au_div_iters(input int w1, input int w2);
        return w1 + 2 * w2 + AU_ROUND_EXTRA;
    endfunction

endpackage

// File: rtl/au_div_step.sv
// One combinational restoring-division step.
// Shifts a dividend bit into the remainder and conditionally subtracts.
`timescale 1ns/1ps
module au_div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] divisor,
    input  logic         bit_in,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] shifted;

    // Remainder after subtraction is below divisor, so N bits suffice.
    always_comb begin
        shifted  = {rem, bit_in};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = shifted[N-1:0] - (q_bit ? divisor : '0);
    end

endmodule

// File: rtl/au_div.sv
// Sequential unsigned fixed-point divider, one quotient bit per cycle.
// Define AU_DIV_ROUND_EN for round-half-up via an extra guard step.
`timescale 1ns/1ps
module au_div
    import au_pkg::*;
#(
    parameter int WIDTH_1 = AU_WIDTH_1,
    parameter int WIDTH_2 = AU_WIDTH_2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_1-1:0] x_int,
    input  logic [WIDTH_2-1:0] x_frac,
    input  logic [WIDTH_1-1:0] y_int,
    input  logic [WIDTH_2-1:0] y_frac,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_1-1:0] result_int,
    output logic [WIDTH_2-1:0] result_frac,
    output logic               zero,
    output logic               overflow,
    output logic               div_by_zero
);

    localparam int N    = WIDTH_1 + WIDTH_2;
    localparam int QW   = N + WIDTH_2;
    localparam int ITER = au_div_iters(WIDTH_1, WIDTH_2);
    localparam int CW   = $clog2(ITER + 1);

    au_state_t state, state_next;

    logic [N-1:0]    dvs;
    logic [N-1:0]    rem;
    logic [ITER-1:0] dvd;
    logic [ITER-2:0] quo;
    logic [CW-1:0]   cnt;
    logic            dbz_pend;

    logic [N-1:0]    rem_next;
    logic            q_bit;
    logic [ITER-1:0] quo_next;
    logic [QW:0]     q_full;
    logic            ovf_w;
    logic            accept;
    logic            y_zero;
    logic            last;

    au_div_step #(.N(N)) u_step (
        .rem      (rem),
        .divisor  (dvs),
        .bit_in   (dvd[ITER-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Handshake decode and final quotient assembly.
    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        y_zero   = ({y_int, y_frac} == '0);
        last     = (state == RUN) && (cnt == CW'(1));
        quo_next = {quo, q_bit};
`ifdef AU_DIV_ROUND_EN
        q_full   = {1'b0, quo_next[ITER-1:1]}
                 + {{QW{1'b0}}, quo_next[0]};
`else
        q_full   = {1'b0, quo_next};
`endif
        ovf_w    = |q_full[QW:N];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath; a zero divisor makes one short pass through RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvs         <= '0;
            rem         <= '0;
            dvd         <= '0;
            quo         <= '0;
            cnt         <= '0;
            dbz_pend    <= 1'b0;
            result_int  <= '0;
            result_frac <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvs      <= {y_int, y_frac};
            dvd      <= {x_int, x_frac, {(ITER-N){1'b0}}};
            rem      <= '0;
            quo      <= '0;
            cnt      <= y_zero ? CW'(1) : CW'(ITER);
            dbz_pend <= y_zero;
        end else if (state == RUN) begin
            dvd <= dvd << 1;
            rem <= rem_next;
            quo <= quo_next[ITER-2:0];
            cnt <= cnt - CW'(1);
            if (last) begin
                if (dbz_pend) begin
                    {result_int, result_frac} <= '1;
                    zero        <= 1'b0;
                    overflow    <= 1'b1;
                    div_by_zero <= 1'b1;
                end else begin
                    {result_int, result_frac} <= q_full[N-1:0];
                    zero        <= (q_full[N-1:0] == '0);
                    overflow    <= ovf_w;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
